// File: rtl/mio_pkg.sv
// Shared types and defaults for the memory/IO bus interface.
package mio_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } mioState_t;

  // Error causes are kept distinct so a cause register can be exposed later.
  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RDWR  = 2'd1,
    ERR_ALIGN = 2'd2
  } mioErr_t;

  localparam logic [3:0] DEF_RAM_WAIT = 4'd2;
  localparam logic [3:0] DEF_IO_WAIT  = 4'd3;
  localparam logic [3:0] DEF_IO_HI    = 4'hF;

  function automatic logic isIoAddr(input logic [31:0] addr, input logic [3:0] ioHi);
    return addr[31:28] == ioHi;
  endfunction

endpackage

// File: rtl/mio_bus_if.sv
// Bundles the CPU-side request signals and the RAM/IO device ports of mio_bus.
interface mio_bus_if;

  logic        CPU_MIO;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        MIO_ready;
  logic [31:0] data_out;
  logic        bus_err;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] io_addr;
  logic        io_rd;
  logic        io_we;
  logic [31:0] io_din;
  logic [31:0] io_dout;

  modport slave (
    input  CPU_MIO, MemRead, MemWrite, addr, data_in, ram_dout, io_dout,
    output MIO_ready, data_out, bus_err, ram_addr, ram_we, ram_din,
           io_addr, io_rd, io_we, io_din
  );

  modport master (
    output CPU_MIO, MemRead, MemWrite, addr, data_in, ram_dout, io_dout,
    input  MIO_ready, data_out, bus_err, ram_addr, ram_we, ram_din,
           io_addr, io_rd, io_we, io_din
  );

endinterface

// File: rtl/mio_wait_cnt.sv
// Loadable 4-bit wait-state down-counter; o_last flags the final wait cycle.
module mio_wait_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic       i_en,
  input  logic [3:0] i_value,
  output logic       o_last
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_last = (r_count == 4'd1);

endmodule

// File: rtl/mio_bus.sv
// Memory/IO bus front end: accepts CPU requests, decodes RAM vs IO space,
// inserts per-region wait states and returns MIO_ready with registered read data.
module mio_bus
  import mio_pkg::*;
#(
  parameter logic [3:0] RAM_WAIT = DEF_RAM_WAIT,
  parameter logic [3:0] IO_WAIT  = DEF_IO_WAIT,
  parameter logic [3:0] IO_HI    = DEF_IO_HI
) (
  input logic       clk,
  input logic       reset,
  mio_bus_if.slave  bus
);

  mioState_t   r_state;
  mioState_t   w_next;
  mioErr_t     r_errCause;
  mioErr_t     w_errCause;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_dataOut;
  logic        r_wr;
  logic        r_io;
  logic        w_req;
  logic        w_accept;
  logic        w_cntLoad;
  logic        w_cntEn;
  logic        w_last;
  logic [3:0]  w_waitVal;

  assign w_req     = bus.CPU_MIO & (bus.MemRead | bus.MemWrite);
  assign w_accept  = (r_state == S_IDLE) & w_req;
  assign w_waitVal = isIoAddr(bus.addr, IO_HI) ? IO_WAIT : RAM_WAIT;
  assign w_cntLoad = w_accept & (w_errCause == ERR_NONE);
  assign w_cntEn   = (r_state == S_WAIT);

  always_comb begin
    w_errCause = ERR_NONE;
    if (bus.MemRead && bus.MemWrite) begin
      w_errCause = ERR_RDWR;
    end else if (bus.addr[1:0] != 2'b00) begin
      w_errCause = ERR_ALIGN;
    end
  end

  mio_wait_cnt u_waitCnt (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_cntLoad),
    .i_en    (w_cntEn),
    .i_value (w_waitVal),
    .o_last  (w_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Rejected requests still latch so the error cause is visible in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_wr       <= 1'b0;
      r_io       <= 1'b0;
      r_errCause <= ERR_NONE;
    end else if (w_accept) begin
      r_addr     <= bus.addr;
      r_data     <= bus.data_in;
      r_wr       <= bus.MemWrite;
      r_io       <= isIoAddr(bus.addr, IO_HI);
      r_errCause <= w_errCause;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dataOut <= '0;
    end else if ((r_state == S_WAIT) && w_last && !r_wr) begin
      r_dataOut <= r_io ? bus.io_dout : bus.ram_dout;
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.MIO_ready = 1'b0;
    bus.bus_err   = 1'b0;
    bus.ram_we    = 1'b0;
    bus.io_we     = 1'b0;
    bus.io_rd     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.MIO_ready = !w_req;
        if (w_req) begin
          w_next = (w_errCause != ERR_NONE) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        bus.io_rd = r_io & !r_wr;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.MIO_ready = 1'b1;
        bus.bus_err   = (r_errCause != ERR_NONE);
        bus.ram_we    = (r_errCause == ERR_NONE) & r_wr & !r_io;
        bus.io_we     = (r_errCause == ERR_NONE) & r_wr & r_io;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.data_out = r_dataOut;
  assign bus.ram_addr = r_addr[11:2];
  assign bus.ram_din  = r_data;
  assign bus.io_addr  = r_addr;
  assign bus.io_din   = r_data;

endmodule
